mac_dot_seq: RTL and testbench

Dot-product sequencer that drives the `MAC` block's operand interface (`rst`/`en`/`A`/`B` in, `out`/`ovr` back). It holds two operand vectors in local buffers and, on `start`, does the following:

- clears the MAC;
- streams `len` operand pairs with one `en` pulse each;
- waits out the MAC latency;
- returns the accumulated sign-magnitude Q-format result over a valid/ready port.

It sits between the TPU array controller and each MAC instance.

---
 rtl/mac_pkg.sv | 20 ++
 rtl/mac_operand_buf.sv | 38 +++
 rtl/mac_dot_seq.sv | 198 +++++++++++++++++++
 tb/tb_mac_dot_seq.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and constants for the MAC dot-product sequencer.
// Word format is sign-magnitude Q-format: sign, integer bits, Q fraction bits.
package mac_pkg;

  localparam int DEF_Q = 10;
  localparam int DEF_N = 32;
  localparam int SIGN_BIT = DEF_N - 1;

  // Fixed-point 1.0 in the default format
  localparam logic [DEF_N-1:0] FIX_ONE = DEF_N'(1) << DEF_Q;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } seq_state_t;

endpackage

// File: rtl/mac_operand_buf.sv
// Operand storage: two DEPTH x N register files (A and B), one write port
// selected by wr_sel, one shared combinational read index.
// Ports: clk, wr_en/wr_sel/wr_addr/wr_data write side; rd_addr in;
// rd_a/rd_b out. Contents are never reset.
module mac_operand_buf
  import mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N-1:0]             wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [N-1:0]             rd_a,
  output logic [N-1:0]             rd_b
);

  logic [N-1:0] mem_a [DEPTH];
  logic [N-1:0] mem_b [DEPTH];

  // No reset on purpose: operands survive rst and job boundaries
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel) begin
        mem_b[wr_addr] <= wr_data;
      end else begin
        mem_a[wr_addr] <= wr_data;
      end
    end
  end

  assign rd_a = mem_a[rd_addr];
  assign rd_b = mem_b[rd_addr];

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product sequencer: clears a MAC, streams len operand pairs from local
// buffers, waits out the MAC latency and returns the result on valid/ready.
// Ports: clk, rst (sync, active-high); wr_* buffer write port; start/len job
// request; busy; mac_rst/mac_en/mac_A/mac_B to the MAC and mac_out/mac_ovr
// back; res_valid/res_ready/res_data/res_ovr result port. All outputs are
// registered.
module mac_dot_seq
  import mac_pkg::*;
#(
  parameter int Q       = DEF_Q,
  parameter int N       = DEF_N,
  parameter int DEPTH   = 16,
  parameter int MAC_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic                     wr_sel,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [N-1:0]             wr_data,
  input  logic                     start,
  input  logic [$clog2(DEPTH):0]   len,
  output logic                     busy,
  output logic                     mac_rst,
  output logic                     mac_en,
  output logic [N-1:0]             mac_A,
  output logic [N-1:0]             mac_B,
  input  logic [N-1:0]             mac_out,
  input  logic                     mac_ovr,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [N-1:0]             res_data,
  output logic                     res_ovr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(MAC_LAT - 1);

  if (Q < 0 || Q > N - 2) begin : g_bad_q
    $error("mac_dot_seq: Q does not fit in N");
  end
  if (MAC_LAT < 1) begin : g_bad_lat
    $error("mac_dot_seq: MAC_LAT must be at least 1");
  end

  seq_state_t state, state_d;

  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dcnt_q, dcnt_d;
  logic [AW-1:0] rd_idx;
  logic [N-1:0]  rd_a, rd_b;

  logic          busy_d, mac_rst_d, mac_en_d;
  logic          res_valid_d, res_ovr_d;
  logic [N-1:0]  mac_A_d, mac_B_d, res_data_d;

  logic          accept, wr_ok;

  assign accept = (state == S_IDLE) && start;
  // A write coinciding with an accepted start loses: busy is treated as set
  assign wr_ok  = wr_en && !busy && !accept;

  // cnt_q points at the element to issue next while feeding
  assign rd_idx = (state == S_FEED) ? cnt_q[AW-1:0] : '0;

  mac_operand_buf #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_idx),
    .rd_a    (rd_a),
    .rd_b    (rd_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    len_d       = len_q;
    cnt_d       = cnt_q;
    dcnt_d      = dcnt_q;
    busy_d      = busy;
    mac_rst_d   = 1'b0;
    mac_en_d    = 1'b0;
    mac_A_d     = '0;
    mac_B_d     = '0;
    res_valid_d = res_valid;
    res_data_d  = res_data;
    res_ovr_d   = res_ovr;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLEAR;
          len_d     = (len > DEPTH_L) ? DEPTH_L : len;
          busy_d    = 1'b1;
          mac_rst_d = 1'b1;
        end
      end

      S_CLEAR: begin
        res_ovr_d  = 1'b0;
        res_data_d = '0;
        if (len_q == '0) begin
          state_d     = S_DONE;
          res_valid_d = 1'b1;
        end else begin
          // First pair is launched straight out of CLEAR
          state_d  = S_FEED;
          mac_en_d = 1'b1;
          mac_A_d  = rd_a;
          mac_B_d  = rd_b;
          cnt_d    = LW'(1);
        end
      end

      S_FEED: begin
        res_ovr_d = res_ovr | mac_ovr;
        if (cnt_q == len_q) begin
          state_d = S_DRAIN;
          dcnt_d  = '0;
        end else begin
          mac_en_d = 1'b1;
          mac_A_d  = rd_a;
          mac_B_d  = rd_b;
          cnt_d    = cnt_q + LW'(1);
        end
      end

      S_DRAIN: begin
        res_ovr_d = res_ovr | mac_ovr;
        if (dcnt_q == DRAIN_LAST) begin
          state_d     = S_DONE;
          res_data_d  = mac_out;
          res_valid_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end

      S_DONE: begin
        if (res_ready) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      busy      <= 1'b0;
      mac_rst   <= 1'b1;
      mac_en    <= 1'b0;
      mac_A     <= '0;
      mac_B     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_ovr   <= 1'b0;
    end else begin
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      dcnt_q    <= dcnt_d;
      busy      <= busy_d;
      mac_rst   <= mac_rst_d;
      mac_en    <= mac_en_d;
      mac_A     <= mac_A_d;
      mac_B     <= mac_B_d;
      res_valid <= res_valid_d;
      res_data  <= res_data_d;
      res_ovr   <= res_ovr_d;
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// Self-checking bench for mac_dot_seq with a behavioural Q10 sign-magnitude
// MAC (latency 1) attached to the operand interface.
module tb_mac_dot_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        wr_sel;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        start;
  logic [4:0]  len_in;
  logic        busy;
  logic        mac_rst;
  logic        mac_en;
  logic [31:0] mac_A;
  logic [31:0] mac_B;
  logic [31:0] mac_out = '0;
  logic        mac_ovr = 1'b0;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_ovr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_dot_seq #(
    .Q       (10),
    .N       (32),
    .DEPTH   (16),
    .MAC_LAT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .len       (len_in),
    .busy      (busy),
    .mac_rst   (mac_rst),
    .mac_en    (mac_en),
    .mac_A     (mac_A),
    .mac_B     (mac_B),
    .mac_out   (mac_out),
    .mac_ovr   (mac_ovr),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_ovr   (res_ovr)
  );

  // Behavioural MAC: sign-magnitude Q10 accumulate, out valid one cycle after en
  longint acc = 0;

  function automatic longint sm2i(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  always @(posedge clk) begin
    longint p, mag;
    if (mac_rst === 1'b1) begin
      acc = 0;
      mac_out <= '0;
      mac_ovr <= 1'b0;
    end else if (mac_en === 1'b1) begin
      p = (sm2i(mac_A) * sm2i(mac_B)) / 1024;
      acc = acc + p;
      mag = (acc < 0) ? -acc : acc;
      mac_ovr <= mac_ovr | (mag > 64'sh7FFF_FFFF);
      mac_out <= {acc < 0, mag[30:0]};
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr, input logic [31:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = 4'(addr);
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  typedef struct packed {
    logic [4:0]       len;
    logic [3:0][31:0] a;
    logic [3:0][31:0] b;
    logic [31:0]      data;
    logic [4:0]       lat;
  } vec_t;

  vec_t vecs[4];

  task automatic load(input vec_t v);
    for (int i = 0; i < int'(v.len) && i < 4; i++) begin
      wr(1'b0, i, v.a[i]);
      wr(1'b1, i, v.b[i]);
    end
  endtask

  // Issues a job and observes it up to res_valid; optional hold cycles with
  // stray start/wr_en pulses; optional write alongside start.
  task automatic run_job(input logic [4:0] l, input int hold,
                         input logic wr_with_start,
                         output int lat, output int ens, output int rsts,
                         output logic [31:0] d, output logic o);
    @(negedge clk);
    start  = 1'b1;
    len_in = l;
    if (wr_with_start) begin
      wr_en   = 1'b1;
      wr_sel  = 1'b0;
      wr_addr = 4'd0;
      wr_data = 32'h7FFF_FFFF;
    end
    lat  = -1;
    ens  = 0;
    rsts = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (mac_en) ens++;
      if (mac_rst) rsts++;
      if (res_valid) begin
        lat = c;
        break;
      end
    end
    d = res_data;
    o = res_ovr;
    for (int h = 0; h < hold; h++) begin
      if (h == 1) begin
        start   = 1'b1;
        len_in  = 5'd2;
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd0;
        wr_data = 32'h7FFF_FFFF;
      end
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      chk("hold_data", res_data, d);
      chk("hold_valid", {31'b0, res_valid}, 32'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("valid_drop", {31'b0, res_valid}, 32'd0);
    chk("busy_drop", {31'b0, busy}, 32'd0);
  endtask

  function automatic vec_t mk(input logic [4:0] l,
                              input logic [31:0] a0, a1, a2, a3,
                              input logic [31:0] b0, b1, b2, b3,
                              input logic [31:0] dd, input logic [4:0] lt);
    vec_t v;
    v.len  = l;
    v.a    = {a3, a2, a1, a0};
    v.b    = {b3, b2, b1, b0};
    v.data = dd;
    v.lat  = lt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, ens, rsts, n;
    logic [31:0] d;
    logic o;
    logic seen;

    vecs[0] = mk(5'd3, 32'h400, 32'hC00, 32'h1400, 32'h0,
                 32'h800, 32'h800, 32'h1400, 32'h0, 32'h8400, 5'd6);
    vecs[1] = mk(5'd4, 32'h1400, 32'h800, 32'h8000_0C00, 32'h8000_0800,
                 32'h2000, 32'hC00, 32'h1000, 32'h8000_0800,
                 32'h9800, 5'd7);
    vecs[2] = mk(5'd2, 32'h200, 32'h100, 32'h0, 32'h0,
                 32'h200, 32'h600, 32'h0, 32'h0, 32'h280, 5'd5);
    vecs[3] = mk(5'd0, 32'h0, 32'h0, 32'h0, 32'h0,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd2);

    rst = 1'b1;
    wr_en = 1'b0;
    wr_sel = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    start = 1'b0;
    len_in = '0;
    res_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mac_rst", {31'b0, mac_rst}, 32'd1);
    chk("rst_mac_en", {31'b0, mac_en}, 32'd0);
    chk("rst_mac_A", mac_A, 32'd0);
    chk("rst_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_data", res_data, 32'd0);
    chk("rst_ovr", {31'b0, res_ovr}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_mac_rst", {31'b0, mac_rst}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      load(vecs[k]);
      run_job(vecs[k].len, 0, 1'b0, lat, ens, rsts, d, o);
      chk("job_lat", 32'(lat), 32'(vecs[k].lat));
      chk("job_ens", 32'(ens), 32'(vecs[k].len));
      chk("job_rsts", 32'(rsts), 32'd1);
      chk("job_data", d, vecs[k].data);
      chk("job_ovr", {31'b0, o}, 32'd0);
      chk("idle_mac_A", mac_A, 32'd0);
    end

    // len above DEPTH saturates to 16 pairs of 1.0 * 1.0
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, i, 32'h400);
      wr(1'b1, i, 32'h400);
    end
    run_job(5'd20, 0, 1'b0, lat, ens, rsts, d, o);
    chk("sat_lat", 32'(lat), 32'd19);
    chk("sat_ens", 32'(ens), 32'd16);
    chk("sat_data", d, 32'h4000);

    // 2^20 * 2^20 overflows; the following job must start with res_ovr clear
    wr(1'b0, 0, 32'h4000_0000);
    wr(1'b1, 0, 32'h4000_0000);
    run_job(5'd1, 0, 1'b0, lat, ens, rsts, d, o);
    chk("ovf_ovr", {31'b0, o}, 32'd1);
    chk("ovf_lat", 32'(lat), 32'd4);
    load(vecs[0]);
    run_job(5'd3, 0, 1'b0, lat, ens, rsts, d, o);
    chk("ovr_clear", {31'b0, o}, 32'd0);
    chk("ovr_clear_data", d, 32'h8400);

    // Backpressure with stray start/wr_en during the hold
    run_job(5'd3, 5, 1'b0, lat, ens, rsts, d, o);
    chk("bp_data", d, 32'h8400);
    @(negedge clk);
    chk("bp_no_queue", {31'b0, busy}, 32'd0);
    // Write coinciding with start is dropped; A[0] must still read 1.0
    run_job(5'd3, 0, 1'b1, lat, ens, rsts, d, o);
    chk("bp_rerun_data", d, 32'h8400);
    chk("wr_start_drop", d, 32'h8400);

    // Reset in the 2nd FEED cycle
    @(negedge clk);
    start  = 1'b1;
    len_in = 5'd3;
    n = 0;
    seen = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (mac_en) n++;
      if (n == 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("mid_seen_feed2", {31'b0, seen}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_busy", {31'b0, busy}, 32'd0);
    chk("mid_mac_en", {31'b0, mac_en}, 32'd0);
    chk("mid_valid", {31'b0, res_valid}, 32'd0);
    chk("mid_mac_rst", {31'b0, mac_rst}, 32'd1);
    chk("mid_data", res_data, 32'd0);
    run_job(5'd3, 0, 1'b0, lat, ens, rsts, d, o);
    chk("mid_rerun_data", d, 32'h8400);
    chk("mid_rerun_lat", 32'(lat), 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
